// File: rtl/mul_div_seq.sv
// mul_div_seq: iterative 32-step multiply/divide unit for the EX stage.
// Owns HI/LO and stalls ID/EX while an operation is in flight.

module ALU_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  alu_op,
  input  logic        invert_b,
  input  logic        carry_in,
  output logic [31:0] result,
  output logic        carry_out
);

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  logic [31:0] bx;
  logic [31:0] sum;
  logic        c;

  // condition B so add with carry_in=1 performs a - b
  always_comb begin
    bx = invert_b ? ~b : b;
  end

  // ripple-carry adder; final carry is the "no borrow" flag on subtract
  always_comb begin
    c   = carry_in;
    sum = '0;
    for (int i = 0; i < 32; i++) begin
      sum[i] = a[i] ^ bx[i] ^ c;
      c      = (a[i] & bx[i]) | (c & (a[i] ^ bx[i]));
    end
    carry_out = c;
  end

  // function select
  always_comb begin
    result = '0;
    case (alu_op)
      OP_AND:  result = a & bx;
      OP_OR:   result = a | bx;
      OP_ADD:  result = sum;
      OP_XOR:  result = a ^ bx;
      default: result = '0;
    endcase
  end

endmodule

module mul_div_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  logic        flush,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b10;

  state_t      state;
  logic [1:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] operand;
  logic [63:0] work;
  logic [4:0]  count;
  logic        neg_lo;
  logic        neg_hi;

  logic        is_div;
  logic        is_sgn;
  logic        accept;
  logic [31:0] abs_a;
  logic [31:0] abs_b;

  logic [31:0] alu_a;
  logic [31:0] alu_res;
  logic        alu_inv;
  logic        alu_cout;

  logic        take;
  logic [63:0] step_nxt;

  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;

  // hold ID/EX while busy and in the cycle a new op is requested
  assign stall = busy | (start & ~busy);

  // decode latched op and form operand magnitudes
  always_comb begin
    is_div = op_q[1];
    is_sgn = ~op_q[0];
    abs_a  = (is_sgn & a_q[31]) ? (~a_q + 32'd1) : a_q;
    abs_b  = (is_sgn & b_q[31]) ? (~b_q + 32'd1) : b_q;
  end

  // a new request is taken in IDLE (unless flushed) or in DONE
  always_comb begin
    accept = 1'b0;
    unique case (state)
      S_IDLE:  accept = start & ~flush;
      S_DONE:  accept = start;
      default: accept = 1'b0;
    endcase
  end

  // ALU operands: add multiplicand, or subtract divisor from shifted rem
  always_comb begin
    alu_a   = is_div ? work[62:31] : work[63:32];
    alu_inv = is_div;
  end

  ALU_32bit u_alu (
    .a         (alu_a),
    .b         (operand),
    .alu_op    (ALU_ADD),
    .invert_b  (alu_inv),
    .carry_in  (alu_inv),
    .result    (alu_res),
    .carry_out (alu_cout)
  );

  // one shift-add or restoring shift-subtract iteration
  always_comb begin
    take     = work[63] | alu_cout;
    step_nxt = work;
    if (is_div) begin
      if (take) begin
        step_nxt = {alu_res, work[30:0], 1'b1};
      end else begin
        step_nxt = {work[62:0], 1'b0};
      end
    end else begin
      if (work[0]) begin
        step_nxt = {alu_cout, alu_res, work[31:1]};
      end else begin
        step_nxt = {1'b0, work[63:32], work[31:1]};
      end
    end
  end

  // sign correction and divide-by-zero override
  always_comb begin
    prod   = neg_lo ? (~work + 64'd1) : work;
    quo    = neg_lo ? (~work[31:0] + 32'd1) : work[31:0];
    rem    = neg_hi ? (~work[63:32] + 32'd1) : work[63:32];
    fix_hi = prod[63:32];
    fix_lo = prod[31:0];
    if (is_div) begin
      if (b_q == 32'd0) begin
        fix_hi = a_q;
        fix_lo = 32'hFFFF_FFFF;
      end else begin
        fix_hi = rem;
        fix_lo = quo;
      end
    end
  end

  // sequencer with registered busy/done and HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      count   <= '0;
      work    <= '0;
      operand <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      neg_lo  <= 1'b0;
      neg_hi  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            op_q  <= op;
            a_q   <= srcA;
            b_q   <= srcB;
            busy  <= 1'b1;
            state <= S_PREP;
          end else begin
            state <= S_IDLE;
          end
        end
        S_PREP: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            operand <= is_div ? abs_b : abs_a;
            work    <= {32'd0, is_div ? abs_a : abs_b};
            neg_lo  <= is_sgn & (a_q[31] ^ b_q[31]);
            neg_hi  <= is_sgn &
                       (is_div ? a_q[31]
                               : (a_q[31] ^ b_q[31]));
            count   <= 5'd31;
            state   <= S_CALC;
          end
        end
        S_CALC: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            work <= step_nxt;
            if (count == 5'd0) begin
              state <= S_FIX;
            end else begin
              count <= count - 5'd1;
            end
          end
        end
        S_FIX: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            hi    <= fix_hi;
            lo    <= fix_lo;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_seq.sv
// tb_mul_div_seq: directed and random checks of mul_div_seq
// against an arithmetic reference model.

module tb_mul_div_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        flush;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_chk = 0;
  int n_pass = 0;

  mul_div_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .srcA  (srcA),
    .srcB  (srcB),
    .flush (flush),
    .busy  (busy),
    .stall (stall),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  logic [1:0]  d_op [7] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd2, 2'd3, 2'd2};
  logic [31:0] d_a  [7] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd100,
                            32'hFFFFFFF9, 32'h80000000, 32'h1234,
                            32'hFFFFFFF0};
  logic [31:0] d_b  [7] = '{32'd5, 32'hFFFFFFFF, 32'd7, 32'd2,
                            32'hFFFFFFFF, 32'd0, 32'd0};
  logic [31:0] d_hi [7] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'd2,
                            32'hFFFFFFFF, 32'd0, 32'h1234,
                            32'hFFFFFFF0};
  logic [31:0] d_lo [7] = '{32'hFFFFFFF1, 32'h00000001, 32'd14,
                            32'hFFFFFFFD, 32'h80000000,
                            32'hFFFFFFFF, 32'hFFFFFFFF};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {hi, lo} from plain arithmetic
  function automatic logic [63:0] model(input logic [1:0] o,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint      p;
    logic [63:0] u;
    int          sa;
    int          sb;
    logic [31:0] q;
    logic [31:0] r;
    sa = a;
    sb = b;
    case (o)
      2'd0: begin
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
      end
      2'd1: begin
        u = {32'd0, a};
        return u * {32'd0, b};
      end
      2'd2: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF)
          return {32'd0, 32'h80000000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(5))
      0:       return 32'h0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'($urandom_range(15));
      default: return $urandom;
    endcase
  endfunction

  // issue one op, return done latency, busy cycles and result
  task automatic do_op(input logic [1:0] o,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       output int lat,
                       output int nbusy,
                       output logic [31:0] h,
                       output logic [31:0] l);
    start = 1'b1;
    op    = o;
    srcA  = a;
    srcB  = b;
    lat   = -1;
    nbusy = 0;
    h     = 'x;
    l     = 'x;
    for (int k = 1; k <= 60; k++) begin
      step();
      if (k == 1) begin
        start = 1'b0;
        op    = 2'($urandom_range(3));
        srcA  = $urandom;
        srcB  = $urandom;
      end
      if (busy) nbusy++;
      if (done) begin
        lat = k;
        h   = hi;
        l   = lo;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    op    = 2'd0;
    srcA  = '0;
    srcB  = '0;
    #2;
    n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
    n_chk++; if (done !== 1'b0) $display("FAIL rst_done got %b want 0", done); else n_pass++;
    n_chk++; if (stall !== 1'b0) $display("FAIL rst_stall got %b want 0", stall); else n_pass++;
    n_chk++; if (hi !== 32'd0) $display("FAIL rst_hi got %h want 0", hi); else n_pass++;
    n_chk++; if (lo !== 32'd0) $display("FAIL rst_lo got %h want 0", lo); else n_pass++;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_directed();
    int lat;
    int nb;
    logic [31:0] h;
    logic [31:0] l;
    for (int i = 0; i < 7; i++) begin
      do_op(d_op[i], d_a[i], d_b[i], lat, nb, h, l);
      n_chk++; if (lat !== 35) $display("FAIL dir%0d_latency got %0d want 35", i, lat); else n_pass++;
      n_chk++; if (nb !== 34) $display("FAIL dir%0d_busy_cycles got %0d want 34", i, nb); else n_pass++;
      n_chk++; if (h !== d_hi[i]) $display("FAIL dir%0d_hi got %h want %h", i, h, d_hi[i]); else n_pass++;
      n_chk++; if (l !== d_lo[i]) $display("FAIL dir%0d_lo got %h want %h", i, l, d_lo[i]); else n_pass++;
      step();
      n_chk++; if (done !== 1'b0) $display("FAIL dir%0d_done_pulse got %b want 0", i, done); else n_pass++;
      n_chk++; if (lo !== d_lo[i]) $display("FAIL dir%0d_lo_hold got %h want %h", i, lo, d_lo[i]); else n_pass++;
    end
  endtask

  task automatic test_stall();
    int ns;
    bit seen;
    start = 1'b1;
    op    = 2'd1;
    srcA  = $urandom;
    srcB  = $urandom;
    #1;
    n_chk++; if (stall !== 1'b1) $display("FAIL stall_comb got %b want 1", stall); else n_pass++;
    ns   = 0;
    seen = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 1) start = 1'b0;
      if (done) begin
        seen = 1'b1;
        n_chk++; if (stall !== 1'b0) $display("FAIL stall_at_done got %b want 0", stall); else n_pass++;
        break;
      end
      if (stall) ns++;
    end
    n_chk++; if (seen !== 1'b1) $display("FAIL stall_done_seen got %b want 1", seen); else n_pass++;
    n_chk++; if (ns !== 34) $display("FAIL stall_cycles got %0d want 34", ns); else n_pass++;
  endtask

  task automatic test_random();
    int lat;
    int nb;
    logic [31:0] h;
    logic [31:0] l;
    logic [1:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] e;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(3));
      a = pick();
      b = pick();
      e = model(o, a, b);
      do_op(o, a, b, lat, nb, h, l);
      n_chk++; if (lat !== 35) $display("FAIL rnd%0d_latency got %0d want 35", i, lat); else n_pass++;
      n_chk++; if ({h, l} !== e) $display("FAIL rnd%0d_result op=%0d a=%h b=%h got %h_%h want %h", i, o, a, b, h, l, e); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int lat1;
    int lat2;
    int nb;
    logic [31:0] h;
    logic [31:0] l;
    logic [31:0] a;
    logic [31:0] b;
    a = $urandom;
    b = 32'($urandom_range(1000, 1));
    do_op(2'd0, a, b, lat1, nb, h, l);
    n_chk++; if ({h, l} !== model(2'd0, a, b)) $display("FAIL b2b_first got %h_%h want %h", h, l, model(2'd0, a, b)); else n_pass++;
    do_op(2'd3, a, b, lat2, nb, h, l);
    n_chk++; if (lat1 + lat2 !== 70) $display("FAIL b2b_latency got %0d want 70", lat1 + lat2); else n_pass++;
    n_chk++; if ({h, l} !== model(2'd3, a, b)) $display("FAIL b2b_second got %h_%h want %h", h, l, model(2'd3, a, b)); else n_pass++;
    step();
  endtask

  task automatic test_flush();
    int lat;
    int nb;
    logic [31:0] h;
    logic [31:0] l;
    bit seen;
    do_op(2'd0, 32'd3, 32'd4, lat, nb, h, l);
    n_chk++; if (l !== 32'd12) $display("FAIL flush_pre_lo got %h want c", l); else n_pass++;
    n_chk++; if (h !== 32'd0) $display("FAIL flush_pre_hi got %h want 0", h); else n_pass++;
    step();
    start = 1'b1;
    op    = 2'd1;
    srcA  = 32'd2;
    srcB  = 32'd2;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 1) start = 1'b0;
      if (k == 3) begin
        start = 1'b1;
        srcA  = 32'd7;
      end
      if (k == 6) start = 1'b0;
      if (k == 10) flush = 1'b1;
    end
    step();
    flush = 1'b0;
    n_chk++; if (busy !== 1'b0) $display("FAIL flush_busy got %b want 0", busy); else n_pass++;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done) seen = 1'b1;
      step();
    end
    n_chk++; if (seen !== 1'b0) $display("FAIL flush_no_done got %b want 0", seen); else n_pass++;
    n_chk++; if (hi !== 32'd0) $display("FAIL flush_hi got %h want 0", hi); else n_pass++;
    n_chk++; if (lo !== 32'd12) $display("FAIL flush_lo got %h want c", lo); else n_pass++;
    start = 1'b1;
    flush = 1'b1;
    op    = 2'd0;
    srcA  = 32'd5;
    srcB  = 32'd5;
    step();
    start = 1'b0;
    flush = 1'b0;
    n_chk++; if (busy !== 1'b0) $display("FAIL flush_start_idle got %b want 0", busy); else n_pass++;
    step();
  endtask

  task automatic test_start_ignored();
    int lat;
    bit seen;
    logic [31:0] h;
    logic [31:0] l;
    start = 1'b1;
    op    = 2'd3;
    srcA  = 32'd1000;
    srcB  = 32'd7;
    lat   = -1;
    seen  = 1'b0;
    h     = 'x;
    l     = 'x;
    for (int k = 1; k <= 60; k++) begin
      step();
      op   = 2'($urandom_range(3));
      srcA = $urandom;
      srcB = $urandom;
      if (k == 20) start = 1'b0;
      if (done && !seen) begin
        seen = 1'b1;
        lat  = k;
        h    = hi;
        l    = lo;
        break;
      end
    end
    start = 1'b0;
    n_chk++; if (lat !== 35) $display("FAIL ign_latency got %0d want 35", lat); else n_pass++;
    n_chk++; if ({h, l} !== {32'd6, 32'd142}) $display("FAIL ign_result got %h_%h want %h_%h", h, l, 32'd6, 32'd142); else n_pass++;
    step();
  endtask

  task automatic test_reset_mid();
    int lat;
    int nb;
    logic [31:0] h;
    logic [31:0] l;
    start = 1'b1;
    op    = 2'd1;
    srcA  = $urandom;
    srcB  = $urandom;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 1) start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    n_chk++; if (busy !== 1'b0) $display("FAIL mrst_busy got %b want 0", busy); else n_pass++;
    n_chk++; if (stall !== 1'b0) $display("FAIL mrst_stall got %b want 0", stall); else n_pass++;
    n_chk++; if (done !== 1'b0) $display("FAIL mrst_done got %b want 0", done); else n_pass++;
    n_chk++; if (hi !== 32'd0) $display("FAIL mrst_hi got %h want 0", hi); else n_pass++;
    n_chk++; if (lo !== 32'd0) $display("FAIL mrst_lo got %h want 0", lo); else n_pass++;
    step();
    step();
    rst_n = 1'b1;
    step();
    do_op(2'd3, 32'd9, 32'd3, lat, nb, h, l);
    n_chk++; if (lat !== 35) $display("FAIL mrst_div_latency got %0d want 35", lat); else n_pass++;
    n_chk++; if (l !== 32'd3) $display("FAIL mrst_div_lo got %h want 3", l); else n_pass++;
    n_chk++; if (h !== 32'd0) $display("FAIL mrst_div_hi got %h want 0", h); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_random();
    test_back_to_back();
    test_flush();
    test_start_ignored();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mul_div_seq.md
# mul_div_seq

Multi-cycle multiply/divide sequencer for the EX stage of the 5-stage pipeline. Implements MULT, MULTU, DIV, DIVU by iterating 32 shift-and-add (multiply) or restoring shift-and-subtract (divide) steps through one internal ALU_32bit instance. Holds the HI/LO result registers and drives a stall to the hazard unit while an operation is in flight.

## Interface
- No parameters; datapath width fixed at 32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when busy=0.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- srcA  input  32  multiplicand / dividend; sampled with start.
- srcB  input  32  multiplier / divisor; sampled with start.
- flush  input  1  cancel in-flight operation (branch/exception flush).
- busy  output  1  operation in progress.
- stall  output  1  equals busy OR (start AND NOT busy); combinational, holds ID/EX.
- done  output  1  one-cycle pulse; hi/lo valid.
- hi  output  32  HI register (product[63:32] / remainder).
- lo  output  32  LO register (product[31:0] / quotient).

## Operation
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE: start=1 -> latch op/srcA/srcB, go PREP. start=0 -> stay.
- PREP (1 cycle): signed ops take 32-bit magnitudes of operands (|0x80000000| = 0x80000000 unsigned), record result sign (product: signA^signB; quotient: signA^signB; remainder: signA). Clear 64-bit working register, load iteration counter = 31. Go CALC.
- CALC (32 cycles): one step per cycle using ALU_32bit with aluOp = add, invertB/carryIn = 1 for subtract.
  - Multiply: if multiplier LSB=1, upper += multiplicand; shift {carry, upper, lower} right 1.
  - Divide: shift {rem, quot} left 1; rem - divisor; if no borrow (carryOut[31]=1) keep difference and set quot LSB=1, else restore.
  - Counter decrements; at 0 go FIX.
- FIX (1 cycle): negate (two's complement, 64-bit for product, 32-bit each for quotient/remainder) where recorded sign is 1. Go DONE.
- DONE (1 cycle): hi/lo written at entry, done=1. Go IDLE; a start in DONE is accepted (goes PREP, busy=0 in DONE).
- Divide by zero (srcB=0, any div op): result forced hi=srcA, lo=0xFFFFFFFF; full latency still applies.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Signed division truncates toward zero; remainder takes dividend's sign.
- flush=1 in PREP/CALC/FIX: next state IDLE, hi/lo unchanged, no done. flush in IDLE/DONE: no effect (DONE still completes). flush and start same cycle in IDLE: start ignored.
- start while busy=1: ignored, operands not resampled.

## Timing
- Reset: state IDLE, busy=0, done=0, hi=0, lo=0, counter=0, working regs=0. Reset mid-operation aborts immediately.
- Start sampled cycle N; PREP N+1; CALC N+2..N+33; FIX N+34; DONE N+35.
- busy=1 cycles N+1..N+34; done=1 cycle N+35 only; hi/lo valid from N+35 and held until next DONE.
- stall=1 cycles N..N+34 (combinational in N).
- Back-to-back: start at N+35 -> next done at N+70.

## Test plan
- MULT srcA=0xFFFFFFFD, srcB=5 -> done at start+35, hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high exactly 34 cycles.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; DIVU 100/7 -> lo=14, hi=2.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 0x1234/0 and DIV 0xFFFFFFF0/0 -> hi=srcA, lo=0xFFFFFFFF, done at start+35.
- MULT 3x4 completes (lo=12); then MULTU 2x2 with flush at start+10 -> busy low next cycle, no done, hi=0, lo=12 retained; start pulses while busy ignored.
- Assert rst_n low at start+20 -> all outputs 0 asynchronously; new DIVU 9/3 after release -> lo=3, hi=0.
